// File: rtl/bcd_display_if.sv
// Handshake and display bus between the result-selection stage and bcd_display_driver.
// The master drives the conversion request; the slave (the driver) returns status and display data.
interface bcd_display_if #(
    parameter int n      = 6,
    parameter int DIGITS = 2
);
    logic                  start;
    logic [n-1:0]          res;
    logic                  is_negative;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg_out;
    logic [7*DIGITS-1:0]   hex_out;
    logic [6:0]            hex_sign;

    modport master (
        output start, res, is_negative,
        input  busy, done, bcd_out, neg_out, hex_out, hex_sign
    );

    modport slave (
        input  start, res, is_negative,
        output busy, done, bcd_out, neg_out, hex_out, hex_sign
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Serial double-dabble binary-to-BCD converter driving active-low seven-segment digits and a sign.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_display_driver #(
    parameter int n      = 6,
    parameter int DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    bcd_display_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(n + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [n-1:0]       mag_q;
    logic               sign_q;
    logic               nonzero_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [7*DIGITS-1:0] hex_d;

    logic [ACC_W-1:0]    bcd_q;
    logic                neg_q;
    logic [7*DIGITS-1:0] hex_q;
    logic [6:0]          hex_sign_q;
    logic                done_q;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // NOTE: state_d gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONVERT;
            CONVERT: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every digit that would overflow past 9 after the next shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_shift = {acc_adj[ACC_W-2:0], mag_q[n-1]};
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic leading;

    always_comb begin
        hex_d   = '1;
        leading = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            hex_d[7*i +: 7] = seg7(acc_q[4*i +: 4]);
        // Digit 0 is never blanked, so a zero result still shows "0".
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (acc_q[4*i +: 4] != 4'd0)
                leading = 1'b0;
            if (leading)
                hex_d[7*i +: 7] = SEG_BLANK;
        end
    end
`else
    always_comb begin
        hex_d = '1;
        for (int i = 0; i < DIGITS; i++)
            hex_d[7*i +: 7] = seg7(acc_q[4*i +: 4]);
    end
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Working registers are reset too, so a conversion abandoned by reset leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q     <= '0;
            sign_q    <= 1'b0;
            nonzero_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mag_q     <= bus.res;
                        sign_q    <= bus.is_negative;
                        nonzero_q <= |bus.res;
                        acc_q     <= '0;
                        cnt_q     <= CNT_W'(n);
                    end
                end
                CONVERT: begin
                    acc_q <= acc_shift;
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Display registers only change on the DONE cycle and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            hex_q      <= '1;
            hex_sign_q <= SEG_BLANK;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == DONE) begin
                bcd_q      <= acc_q;
                neg_q      <= sign_q & nonzero_q;
                hex_q      <= hex_d;
                hex_sign_q <= (sign_q & nonzero_q) ? SEG_MINUS : SEG_BLANK;
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.neg_out  = neg_q;
    assign bus.hex_out  = hex_q;
    assign bus.hex_sign = hex_sign_q;
endmodule
